counter_driver: RTL

COUNTER_DRIVER -- requirements
Module: counter_driver

---
 rtl/counter_driver_if.sv | 33 +++
 rtl/counter_driver.sv | 132 +++++++++++++
 2 files changed

// File: rtl/counter_driver_if.sv
// Bus between an upstream requester, counter_driver and the downstream counter.
// The slave modport is the driver's view; master is the requester/counter side.
interface counter_driver_if;
    logic       init_req;
    logic [3:0] init_value;
    logic       inc_valid;
    logic [1:0] inc_amt;
    logic       inc_ready;
    logic       dec_valid;
    logic [1:0] dec_amt;
    logic       dec_ready;
    logic       reinit;
    logic [3:0] initial_value;
    logic       incr_valid;
    logic [1:0] incr;
    logic       decr_valid;
    logic [1:0] decr;
    logic [3:0] shadow;
    logic       ovf_err;
    logic       unf_err;

    modport slave (
        input  init_req, init_value, inc_valid, inc_amt, dec_valid, dec_amt,
        output inc_ready, dec_ready, reinit, initial_value,
               incr_valid, incr, decr_valid, decr, shadow, ovf_err, unf_err
    );

    modport master (
        output init_req, init_value, inc_valid, inc_amt, dec_valid, dec_amt,
        input  inc_ready, dec_ready, reinit, initial_value,
               incr_valid, incr, decr_valid, decr, shadow, ovf_err, unf_err
    );
endinterface

// File: rtl/counter_driver.sv
// Issues bounded inc/dec commands to a 4-bit downstream counter, tracking a shadow copy.
// Optional sticky overflow/underflow flags: define CNT_DRV_STICKY_ERR_EN.
module counter_driver (
    input logic             clk,
    input logic             rst,
    counter_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, INIT, RUN} state_e;

    state_e     state_q, state_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] init_cap_q, init_cap_d;
    logic       reinit_q, reinit_d;
    logic [3:0] initial_value_q, initial_value_d;
    logic       incr_valid_q, incr_valid_d;
    logic [1:0] incr_q, incr_d;
    logic       decr_valid_q, decr_valid_d;
    logic [1:0] decr_q, decr_d;

    logic              run_ok;
    logic              inc_ready, dec_ready;
    logic              inc_acc, dec_acc;
    logic signed [5:0] shadow_s, inc_s, dec_s;
    logic signed [5:0] n_both, n_inc, n_dec, shadow_nxt;

    // State register and all datapath flops
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            shadow_q        <= 4'd0;
            init_cap_q      <= 4'd0;
            reinit_q        <= 1'b0;
            initial_value_q <= 4'd0;
            incr_valid_q    <= 1'b0;
            incr_q          <= 2'd0;
            decr_valid_q    <= 1'b0;
            decr_q          <= 2'd0;
        end else begin
            state_q         <= state_d;
            shadow_q        <= shadow_d;
            init_cap_q      <= init_cap_d;
            reinit_q        <= reinit_d;
            initial_value_q <= initial_value_d;
            incr_valid_q    <= incr_valid_d;
            incr_q          <= incr_d;
            decr_valid_q    <= decr_valid_d;
            decr_q          <= decr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.init_req) state_d = INIT;
            INIT:    state_d = RUN;
            RUN:     if (bus.init_req) state_d = INIT;
            default: state_d = IDLE;
        endcase
    end

    // Ready outputs: only RUN without a pending init, and never while rst is held low
    always_comb begin
        shadow_s  = $signed({2'b00, shadow_q});
        inc_s     = $signed({4'b0000, bus.inc_amt});
        dec_s     = $signed({4'b0000, bus.dec_amt});
        n_both    = shadow_s + inc_s - dec_s;
        n_inc     = shadow_s + inc_s;
        n_dec     = shadow_s - dec_s;
        run_ok    = rst && (state_q == RUN) && !bus.init_req;
        inc_ready = run_ok && (bus.dec_valid ? (n_both <= 6'sd15) : (n_inc <= 6'sd15));
        dec_ready = run_ok && (bus.inc_valid ? (n_both >= 6'sd0)  : (n_dec >= 6'sd0));
    end

    always_comb begin
        inc_acc         = bus.inc_valid && inc_ready;
        dec_acc         = bus.dec_valid && dec_ready;
        shadow_nxt      = shadow_s + (inc_acc ? inc_s : 6'sd0) - (dec_acc ? dec_s : 6'sd0);
        shadow_d        = (state_q == INIT) ? init_cap_q : shadow_nxt[3:0];
        init_cap_d      = init_cap_q;
        if (bus.init_req && (state_q != INIT))
            init_cap_d = bus.init_value;
        reinit_d        = (state_q == INIT);
        initial_value_d = (state_q == INIT) ? init_cap_q : initial_value_q;
        incr_valid_d    = inc_acc;
        incr_d          = inc_acc ? bus.inc_amt : 2'd0;
        decr_valid_d    = dec_acc;
        decr_d          = dec_acc ? bus.dec_amt : 2'd0;
    end

    assign bus.inc_ready     = inc_ready;
    assign bus.dec_ready     = dec_ready;
    assign bus.reinit        = reinit_q;
    assign bus.initial_value = initial_value_q;
    assign bus.incr_valid    = incr_valid_q;
    assign bus.incr          = incr_q;
    assign bus.decr_valid    = decr_valid_q;
    assign bus.decr          = decr_q;
    assign bus.shadow        = shadow_q;

`ifdef CNT_DRV_STICKY_ERR_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    // run_ok already excludes init cycles, so a stall here is always a bound stall
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (state_q == INIT) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (run_ok) begin
            if (bus.inc_valid && !inc_ready) ovf_d = 1'b1;
            if (bus.dec_valid && !dec_ready) unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.ovf_err = ovf_q;
    assign bus.unf_err = unf_q;
`else
    assign bus.ovf_err = 1'b0;
    assign bus.unf_err = 1'b0;
`endif
endmodule
